// File: rtl/step_sequencer.sv
// Command-driven stepper move controller: counted moves with one-level-at-a-time
// speed ramping, driving a 4-bit coil phase table.
module step_sequencer #(
  parameter int unsigned PERIOD_SLOW = 700000,
  parameter int unsigned PERIOD_MED  = 450000,
  parameter int unsigned PERIOD_FAST = 230000,
  parameter int unsigned RAMP_STEPS  = 16,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned HALF_STEP   = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_steps,
  input  logic [1:0]       cmd_speed,
  input  logic             abort,
  output logic [3:0]       coils,
  output logic             step_pulse,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] steps_left
);

  localparam int unsigned PMAX =
    (PERIOD_SLOW > PERIOD_MED) ? ((PERIOD_SLOW > PERIOD_FAST) ? PERIOD_SLOW : PERIOD_FAST)
                               : ((PERIOD_MED  > PERIOD_FAST) ? PERIOD_MED  : PERIOD_FAST);
  localparam int unsigned PW  = $clog2(PMAX + 1);
  localparam int unsigned RW  = $clog2(RAMP_STEPS) + 1;
  localparam logic [2:0]  ADV = (HALF_STEP != 0) ? 3'd1 : 3'd2;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state, next_state;
  logic [PW-1:0]   cnt;
  logic [PW-1:0]   period;
  logic [1:0]      cur_level;
  logic [1:0]      target;
  logic [RW-1:0]   ramp_cnt;
  logic [2:0]      idx;
  logic            dir;
  logic            start;
  logic            tick;
  logic [CNT_W-1:0] r_next;
  logic [31:0]     decel_thresh;

  assign r_next       = steps_left - CNT_W'(1);
  assign decel_thresh = RAMP_STEPS * 32'(cur_level - 2'd1);

  always_comb begin
    case (cur_level)
      2'b10:   period = PW'(PERIOD_MED);
      2'b11:   period = PW'(PERIOD_FAST);
      default: period = PW'(PERIOD_SLOW);
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= next_state;
  end

  // abort outranks a same-cycle tick so the pending step is never issued
  always_comb begin
    next_state = state;
    cmd_ready  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    start      = 1'b0;
    tick       = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (cmd_speed == 2'b00 || cmd_steps == '0) begin
            next_state = S_DONE;
          end else begin
            start      = 1'b1;
            next_state = S_RUN;
          end
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (abort) begin
          next_state = S_DONE;
        end else if (cnt == period - PW'(1)) begin
          tick = 1'b1;
          if (r_next == '0) next_state = S_DONE;
        end
      end
      S_DONE: begin
        done       = 1'b1;
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt        <= '0;
      cur_level  <= 2'b01;
      target     <= 2'b01;
      ramp_cnt   <= '0;
      idx        <= 3'd1;
      dir        <= 1'b0;
      steps_left <= '0;
      step_pulse <= 1'b0;
    end else begin
      step_pulse <= tick;
      if (start) begin
        dir        <= cmd_dir;
        target     <= cmd_speed;
        steps_left <= cmd_steps;
        cur_level  <= 2'b01;
        ramp_cnt   <= '0;
        cnt        <= '0;
      end else if (state == S_RUN && !abort) begin
        if (tick) begin
          cnt        <= '0;
          idx        <= dir ? idx + ADV : idx - ADV;
          steps_left <= r_next;
          if (cur_level > 2'b01 && 32'(r_next) <= decel_thresh) begin
            cur_level <= cur_level - 2'd1;
            ramp_cnt  <= '0;
          end else if (cur_level < target && ramp_cnt == RW'(RAMP_STEPS - 1)) begin
            cur_level <= cur_level + 2'd1;
            ramp_cnt  <= '0;
          end else begin
            ramp_cnt  <= ramp_cnt + RW'(1);
          end
        end else begin
          cnt <= cnt + PW'(1);
        end
      end
    end
  end

  always_comb begin
    case (idx)
      3'd0:    coils = 4'b1000;
      3'd1:    coils = 4'b1100;
      3'd2:    coils = 4'b0100;
      3'd3:    coils = 4'b0110;
      3'd4:    coils = 4'b0010;
      3'd5:    coils = 4'b0011;
      3'd6:    coils = 4'b0001;
      default: coils = 4'b1001;
    endcase
  end

endmodule
